// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data RAM arbiter between processor load/store path and loader port
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    typedef enum logic [1:0] {IDLE, CPU_OWN, LDR_OWN} state_t;

    state_t           state;
    state_t           other;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_ldr;
    logic             own_req;
    logic             own_we;
    logic             oth_req;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

    always_comb begin
        own_req   = 1'b0;
        own_we    = 1'b0;
        oth_req   = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        other     = IDLE;
        case (state)
            CPU_OWN: begin
                own_req   = cpu_req;
                own_we    = cpu_we;
                own_addr  = cpu_addr;
                own_wdata = cpu_wdata;
                oth_req   = ldr_req;
                other     = LDR_OWN;
            end
            LDR_OWN: begin
                own_req   = ldr_req;
                own_we    = ldr_we;
                own_addr  = ldr_addr;
                own_wdata = ldr_wdata;
                oth_req   = cpu_req;
                other     = CPU_OWN;
            end
            default: ;
        endcase
    end

    // burst_cnt saturates so an uncontested owner keeps the RAM indefinitely
    assign cnt_inc = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            last_ldr  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (cpu_req && (!ldr_req || last_ldr))
                        state <= CPU_OWN;
                    else if (ldr_req)
                        state <= LDR_OWN;
                end
                CPU_OWN, LDR_OWN: begin
                    if (!own_req) begin
                        burst_cnt <= '0;
                        if (oth_req) begin
                            state    <= other;
                            last_ldr <= (state == LDR_OWN);
                        end else begin
                            state <= IDLE;
                        end
                    end else if (oth_req && cnt_inc == CNT_MAX) begin
                        state     <= other;
                        burst_cnt <= '0;
                        last_ldr  <= (state == LDR_OWN);
                    end else begin
                        burst_cnt <= cnt_inc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    assign cpu_ack   = (state == CPU_OWN) & cpu_req;
    assign ldr_ack   = (state == LDR_OWN) & ldr_req;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign mem_we    = own_we & own_req;
    assign mem_addr  = own_addr;
    assign mem_wdata = own_wdata;
    assign cpu_rdata = cpu_ack ? mem_rdata : '0;
    assign ldr_rdata = ldr_ack ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, cpu_stall, ldr_ack, mem_we;

    logic [31:0] ram [64];

    typedef struct {
        string       nm;
        logic        ca, la, we, st;
        logic [31:0] addr, wd, crd, lrd;
    } exp_t;

    exp_t  sbq[$];
    string phase;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

    // own: hand-specified owner for this cycle (0 idle, 1 cpu, 2 loader); rd: expected read data if acked
    task automatic cyc(input int own, input logic [31:0] rd);
        exp_t e;
        e.nm   = phase;
        e.ca   = (own == 1) && cpu_req;
        e.la   = (own == 2) && ldr_req;
        e.we   = e.ca ? cpu_we : (e.la ? ldr_we : 1'b0);
        e.addr = (own == 1) ? cpu_addr : ((own == 2) ? ldr_addr : 32'h0);
        e.wd   = (own == 1) ? cpu_wdata : ((own == 2) ? ldr_wdata : 32'h0);
        e.crd  = e.ca ? rd : 32'h0;
        e.lrd  = e.la ? rd : 32'h0;
        e.st   = cpu_req && !e.ca;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            if ({cpu_ack, ldr_ack, mem_we, cpu_stall, mem_addr, mem_wdata, cpu_rdata, ldr_rdata} !==
                {e.ca, e.la, e.we, e.st, e.addr, e.wd, e.crd, e.lrd}) begin
                errors++;
                $display("FAIL %s t=%0t got ca=%b la=%b we=%b st=%b addr=%h wd=%h crd=%h lrd=%h exp ca=%b la=%b we=%b st=%b addr=%h wd=%h crd=%h lrd=%h",
                         e.nm, $time, cpu_ack, ldr_ack, mem_we, cpu_stall, mem_addr, mem_wdata, cpu_rdata, ldr_rdata,
                         e.ca, e.la, e.we, e.st, e.addr, e.wd, e.crd, e.lrd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, pending=%0d", sbq.size());
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h20; ldr_wdata = 32'h55;
        @(posedge clk);
        #1;

        phase = "reset_hold";
        cyc(0, 0);
        cyc(0, 0);
        reset = 1'b1;
        phase = "reset_release_idle";
        cyc(0, 0);
        phase = "reset_first_cpu";
        ldr_req = 1'b0;
        cyc(1, 32'h0);
        cpu_req = 1'b0;
        phase = "reset_cpu_drop";
        cyc(1, 0);
        phase = "reset_idle";
        cyc(0, 0);

        phase = "cpu_only_write";
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        cyc(0, 0);
        for (int i = 0; i < 19; i++) cyc(1, (i == 0) ? 32'h0 : 32'hDEADBEEF);
        phase = "cpu_only_read";
        cpu_we = 1'b0;
        cyc(1, 32'hDEADBEEF);
        cpu_req = 1'b0;
        cyc(1, 0);
        cyc(0, 0);

        phase = "burst_fair";
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h10;
        cyc(0, 0);
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 8; i++) cyc((r % 2 == 0) ? 1 : 2, 32'hDEADBEEF);

        phase = "ldr_uncontested";
        cpu_req = 1'b0;
        for (int i = 0; i < 10; i++) cyc(2, 32'hDEADBEEF);
        phase = "handover";
        ldr_req = 1'b0; cpu_req = 1'b1;
        cyc(2, 0);
        cyc(1, 32'hDEADBEEF);
        cpu_req = 1'b0;
        cyc(1, 0);
        cyc(0, 0);

        phase = "preload";
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h0; ldr_wdata = 32'h1;
        cyc(0, 0);
        for (int i = 0; i < 4; i++) begin
            ldr_addr = 32'(4 * i); ldr_wdata = 32'(i + 1);
            cyc(2, 32'h0);
        end
        ldr_req = 1'b0;
        cyc(2, 0);
        cyc(0, 0);
        phase = "cpu_run_read";
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
        cyc(0, 0);
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 32'(4 * i);
            cyc(1, 32'(i + 1));
        end
        cpu_req = 1'b0;
        cyc(1, 0);
        cyc(0, 0);

        phase = "reset_mid_write";
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h30; ldr_wdata = 32'hA5A5A5A5;
        cyc(0, 0);
        reset = 1'b0;
        cyc(0, 0);
        ldr_req = 1'b0;
        cyc(0, 0);
        reset = 1'b1;
        phase = "post_reset_idle";
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 0);
        phase = "cancelled_write_absent";
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
        cyc(0, 0);
        cyc(1, 32'h0);
        cpu_req = 1'b0;
        cyc(1, 0);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data RAM between the processor load/store path and a program/data loader port (bench or boot loader). It grants one owner at a time through a registered state machine with round-robin tie-breaking and a burst limit, so neither side can starve the other. It stalls the processor whenever its access is not granted. It sits between the processor's data-memory signals and the `ram` instance in the top level.

Parameters:
ADDR_W, 32, address width of all address ports.
DATA_W, 32, data width of all data ports.
BURST_MAX, 8, maximum consecutive granted accesses for one owner while the other requests (must be at least 1).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
cpu_req  in  1  processor requests a data-memory access this cycle.
cpu_we  in  1  processor access is a write.
cpu_addr  in  ADDR_W  processor address.
cpu_wdata  in  DATA_W  processor write data.
cpu_rdata  out  DATA_W  read data to processor.
cpu_ack  out  1  processor access performed this cycle.
cpu_stall  out  1  cpu_req & ~cpu_ack; freezes the PC and register write.
ldr_req  in  1  loader requests an access.
ldr_we  in  1  loader access is a write.
ldr_addr  in  ADDR_W  loader address.
ldr_wdata  in  DATA_W  loader write data.
ldr_rdata  out  DATA_W  read data to loader.
ldr_ack  out  1  loader access performed this cycle.
mem_we  out  1  RAM write enable.
mem_addr  out  ADDR_W  RAM address.
mem_wdata  out  DATA_W  RAM write data.
mem_rdata  in  DATA_W  RAM combinational read data.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset=0: state=IDLE, burst_cnt=0, last=LDR (so CPU wins the first tie), all ack/we outputs 0, mem_addr=0, mem_wdata=0, both rdata outputs 0.
- States: IDLE, CPU_OWN, LDR_OWN. The state is registered.
- Memory mux is combinational from the state:
  - CPU_OWN drives cpu_* to mem_*.
  - LDR_OWN drives ldr_* to mem_*.
  - IDLE drives mem_we=0, mem_addr=0, mem_wdata=0.
- mem_we = owner_we & owner_req. mem_we is never high in IDLE or when the owner is not requesting.
- Acks:
  - cpu_ack = (state==CPU_OWN) & cpu_req.
  - ldr_ack = (state==LDR_OWN) & ldr_req.
  - At most one ack is high per cycle.
- Read data: cpu_rdata = mem_rdata when cpu_ack, else 0. ldr_rdata is the same rule with ldr_ack. Reads are valid in the ack cycle (zero added latency once owned).
- Latency: a request arriving in IDLE is acked in the next cycle (1 cycle). A request to the current owner is acked in the same cycle.
- IDLE transitions:
  - Neither requests: stay IDLE.
  - Only one requests: go to that owner.
  - Both request: go to the side that is not `last`.
- Owner state X, other side Y:
  - Each acked cycle increments burst_cnt (saturating at BURST_MAX).
  - If X_req=0: go to Y if Y_req, else IDLE.
  - If X_req=1, Y_req=1 and the post-increment burst_cnt reaches BURST_MAX: go to Y.
  - Otherwise stay in X.
- On every change of owner: burst_cnt←0 and last←previous owner. On entering IDLE: burst_cnt←0.
- Burst limit: an owner gets exactly BURST_MAX consecutive accesses while the other side waits. It gets an unlimited number while the other side is not requesting; burst_cnt saturates and causes no switch.
- Simultaneous events: a Y request rising in the same cycle X drops its request hands over with no idle gap. Requests are sampled only at the rising edge of clk, with no combinational grant from IDLE.
- Reset mid-access: immediate return to IDLE with mem_we=0. A write in progress is cancelled with no partial effect beyond what the RAM already latched.
- Requesters must hold req, we, addr and wdata stable until acked. The arbiter does not buffer requests.

Test Plan:
- Reset: hold reset=0 with cpu_req=ldr_req=1 → all acks 0, mem_we 0, mem_addr 0. Release reset → state CPU_OWN after 1 edge; cpu_ack=1 on the next cycle.
- CPU only: cpu_req=1, cpu_we=1, addr 0x10, wdata 0xDEADBEEF for 20 cycles → cpu_ack every cycle after the first; ldr_ack never high. A following read of 0x10 returns 0xDEADBEEF.
- Burst fairness (BURST_MAX=8): both request continuously from IDLE → CPU acked for 8 cycles, then loader for 8, alternating. cpu_stall=1 exactly during loader slots.
- Handover: loader owns, drops ldr_req in the same cycle cpu_req rises → cpu_ack in the next cycle, with no IDLE cycle between.
- Loader preload then run: loader writes 0x1..0x4 to addresses 0x0..0xC, then deasserts → state IDLE. CPU reads of 0x0..0xC return 0x1..0x4.
- Reset mid-write: assert reset=0 during an LDR_OWN write cycle → mem_we falls asynchronously. After release with no requests, state stays IDLE.
